// File: rtl/inst_fetch_queue.sv
// Instruction-fetch front end: PC generator feeding a DEPTH-entry prefetch queue with a valid/ready output to ID.
// Optional FETCH_BYPASS_EN: when the queue is empty, the word being fetched is presented on out_* in the same cycle.
module inst_fetch_queue #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    PC_STEP    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         fetch_en,
    input  logic                         redirect_en,
    input  logic [ADDR_WIDTH-1:0]        redirect_addr,
    output logic                         inst_ren,
    output logic [ADDR_WIDTH-1:0]        inst_addr,
    input  logic [DATA_WIDTH-1:0]        inst_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ADDR_WIDTH-1:0]        out_addr,
    output logic [ADDR_WIDTH-1:0]        out_addr_next,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int                    PTR_W    = $clog2(DEPTH);
    localparam int                    CNT_W    = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0]      FULL_CNT = CNT_W'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] STEP     = ADDR_WIDTH'(PC_STEP);

    // Handshake: an entry moves to ID in any cycle where out_valid and out_ready are both high.
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] mem_addr [DEPTH];
    logic [DATA_WIDTH-1:0] mem_data [DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      cnt;
    logic                  q_valid;
    logic                  q_pop;
    logic                  push;
    logic                  bypass;

    always_comb begin
        q_valid   = (cnt != '0);
        q_pop     = q_valid & out_ready;
        // A full queue that is popping this cycle still has room for the incoming word.
        inst_ren  = ~rst & fetch_en & ~redirect_en & ((cnt != FULL_CNT) | q_pop);
        inst_addr = pc;
`ifdef FETCH_BYPASS_EN
        bypass    = ~q_valid & inst_ren;
`else
        bypass    = 1'b0;
`endif
        push      = inst_ren & ~(bypass & out_ready);
        out_valid = q_valid | bypass;
        out_addr  = '0;
        out_data  = '0;
        if (q_valid) begin
            out_addr = mem_addr[rd_ptr];
            out_data = mem_data[rd_ptr];
        end else if (bypass) begin
            out_addr = pc;
            out_data = inst_data;
        end
        out_addr_next = out_valid ? out_addr + STEP : '0;
        count         = cnt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc     <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (redirect_en) begin
            // A same-cycle pop was already taken by ID; everything else is dropped.
            pc     <= redirect_addr;
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (inst_ren) pc <= pc + STEP;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (q_pop) rd_ptr <= rd_ptr + PTR_W'(1);
            if (push & ~q_pop) cnt <= cnt + CNT_W'(1);
            else if (~push & q_pop) cnt <= cnt - CNT_W'(1);
        end
    end

    // Storage needs no reset: out_* is gated by cnt.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= pc;
            mem_data[wr_ptr] <= inst_data;
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: reference PC/queue model with an expected-address scoreboard.
module tb_inst_fetch_queue;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int DEPTH = 4;
    localparam int CW = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fetch_en = 1'b0;
    logic          redirect_en = 1'b0;
    logic [AW-1:0] redirect_addr = '0;
    logic          out_ready = 1'b0;
    logic          inst_ren;
    logic [AW-1:0] inst_addr;
    logic [DW-1:0] inst_data;
    logic          out_valid;
    logic [AW-1:0] out_addr;
    logic [AW-1:0] out_addr_next;
    logic [DW-1:0] out_data;
    logic [CW-1:0] count;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h3C5A_9E17;
    endfunction

    assign inst_data = mem_word(inst_addr);

    inst_fetch_queue #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .RESET_PC('0), .PC_STEP(4)
    ) dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en), .redirect_en(redirect_en),
        .redirect_addr(redirect_addr), .inst_ren(inst_ren), .inst_addr(inst_addr),
        .inst_data(inst_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_addr_next(out_addr_next), .out_data(out_data),
        .count(count)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_fail = 0;
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] m_pc = '0;
    logic [AW-1:0] exp_head = '0;
    logic          exp_ren = 1'b0;
    logic          exp_valid = 1'b0;
    logic          exp_bypass = 1'b0;
    logic          exp_pop = 1'b0;
    logic          pend = 1'b0;

    // Advance the model across the clock edge that followed the previous drive.
    task automatic commit();
        if (pend) begin
            if (redirect_en) begin
                exp_q.delete();
                m_pc = redirect_addr;
            end else begin
                if (exp_pop && !exp_bypass) void'(exp_q.pop_front());
                if (exp_ren && !(exp_bypass && out_ready)) exp_q.push_back(m_pc);
                if (exp_ren) m_pc = m_pc + 32'd4;
            end
        end
        pend = 1'b0;
    endtask

    task automatic drive(input logic fe, input logic rd, input logic re, input logic [AW-1:0] ra);
        commit();
        @(negedge clk);
        fetch_en = fe; out_ready = rd; redirect_en = re; redirect_addr = ra;
        #1;
        exp_ren = fe && !re && (exp_q.size() < DEPTH || (exp_q.size() != 0 && rd));
        exp_bypass = 1'b0;
`ifdef FETCH_BYPASS_EN
        exp_bypass = (exp_q.size() == 0) && exp_ren;
`endif
        exp_valid = (exp_q.size() != 0) || exp_bypass;
        exp_head = '0;
        if (exp_q.size() != 0) exp_head = exp_q[0];
        else if (exp_bypass) exp_head = m_pc;
        exp_pop = exp_valid && rd;
        pend = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (inst_ren !== 1'b0) begin n_fail++; $display("FAIL reset_ren got=%b exp=0", inst_ren); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        rst = 1'b0;
        #1;
        n_checks++; if (inst_addr !== 32'h0) begin n_fail++; $display("FAIL reset_pc got=%h exp=0", inst_addr); end
        n_checks++; if (count !== '0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
        n_checks++; if ({out_addr, out_data, out_addr_next} !== '0) begin
            n_fail++; $display("FAIL reset_outs got=%h/%h/%h exp=0", out_addr, out_data, out_addr_next);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b0, '0);
            n_checks++; if (inst_addr !== 32'(i*4)) begin n_fail++; $display("FAIL fill_addr got=%h exp=%h", inst_addr, 32'(i*4)); end
            n_checks++; if (count !== CW'(i)) begin n_fail++; $display("FAIL fill_count got=%0d exp=%0d", count, i); end
            n_checks++; if (inst_ren !== (i < 4)) begin n_fail++; $display("FAIL fill_ren got=%b exp=%b", inst_ren, i < 4); end
        end
    endtask

    task automatic test_drain_full();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, 1'b0, '0);
            n_checks++; if (out_valid !== 1'b1 || out_addr !== 32'(i*4)) begin
                n_fail++; $display("FAIL drain_addr got=%b/%h exp=1/%h", out_valid, out_addr, 32'(i*4));
            end
            n_checks++; if (out_data !== mem_word(exp_head)) begin n_fail++; $display("FAIL drain_data got=%h exp=%h", out_data, mem_word(exp_head)); end
            n_checks++; if (out_addr_next !== 32'(i*4+4)) begin n_fail++; $display("FAIL drain_next got=%h exp=%h", out_addr_next, 32'(i*4+4)); end
            n_checks++; if (count !== CW'(4) || inst_ren !== 1'b1) begin
                n_fail++; $display("FAIL drain_count got=%0d/%b exp=4/1", count, inst_ren);
            end
        end
    endtask

    task automatic test_redirect();
        drive(1'b0, 1'b1, 1'b0, '0);
        drive(1'b1, 1'b0, 1'b1, 32'h100);
        n_checks++; if (count !== CW'(3) || inst_ren !== 1'b0) begin
            n_fail++; $display("FAIL redir_cycle got=%0d/%b exp=3/0", count, inst_ren);
        end
        drive(1'b1, 1'b0, 1'b0, '0);
        n_checks++; if (count !== '0 || inst_addr !== 32'h100 || inst_ren !== 1'b1) begin
            n_fail++; $display("FAIL redir_next got=%0d/%h/%b exp=0/100/1", count, inst_addr, inst_ren);
        end
        n_checks++; if (out_valid !== exp_valid || out_addr !== exp_head) begin
            n_fail++; $display("FAIL redir_next_out got=%b/%h exp=%b/%h", out_valid, out_addr, exp_valid, exp_head);
        end
        drive(1'b1, 1'b0, 1'b0, '0);
        n_checks++; if (out_valid !== 1'b1 || out_addr !== 32'h100) begin
            n_fail++; $display("FAIL redir_target got=%b/%h exp=1/100", out_valid, out_addr);
        end
    endtask

    task automatic test_redirect_pop();
        int seen = 0;
        int bad = 0;
        drive(1'b1, 1'b0, 1'b1, 32'h20);
        repeat (4) drive(1'b1, 1'b0, 1'b0, '0);
        drive(1'b0, 1'b1, 1'b1, 32'h200);
        n_checks++; if (out_valid !== 1'b1 || out_addr !== 32'h20) begin
            n_fail++; $display("FAIL rpop_head got=%b/%h exp=1/20", out_valid, out_addr);
        end
        if (out_valid && out_ready && out_addr == 32'h20) seen++;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, 1'b0, '0);
            if (out_valid && out_addr == 32'h20) seen++;
            if (out_valid && (out_addr == 32'h24 || out_addr == 32'h28 || out_addr == 32'h2C)) bad++;
            n_checks++; if (out_valid !== exp_valid || out_addr !== exp_head) begin
                n_fail++; $display("FAIL rpop_stream got=%b/%h exp=%b/%h", out_valid, out_addr, exp_valid, exp_head);
            end
        end
        n_checks++; if (seen != 1) begin n_fail++; $display("FAIL rpop_once got=%0d exp=1", seen); end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL rpop_flushed got=%0d exp=0", bad); end
    endtask

    task automatic test_stall();
        logic [AW-1:0] held;
        drive(1'b0, 1'b1, 1'b0, '0);
        held = m_pc;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) drive(1'b0, 1'b1, 1'b0, '0);
            n_checks++; if (inst_addr !== held || inst_ren !== 1'b0) begin
                n_fail++; $display("FAIL stall_pc got=%h/%b exp=%h/0", inst_addr, inst_ren, held);
            end
        end
        n_checks++; if (count !== '0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL stall_drain got=%0d/%b exp=0/0", count, out_valid);
        end
    endtask

    task automatic test_bypass();
        drive(1'b1, 1'b1, 1'b0, '0);
`ifdef FETCH_BYPASS_EN
        n_checks++; if (out_valid !== 1'b1 || out_addr !== m_pc || out_data !== mem_word(m_pc)) begin
            n_fail++; $display("FAIL bypass_out got=%b/%h exp=1/%h", out_valid, out_addr, m_pc);
        end
        drive(1'b0, 1'b0, 1'b0, '0);
        n_checks++; if (count !== '0) begin n_fail++; $display("FAIL bypass_count got=%0d exp=0", count); end
`else
        n_checks++; if (out_valid !== 1'b0 || out_addr !== '0 || inst_ren !== 1'b1) begin
            n_fail++; $display("FAIL nobypass_out got=%b/%h/%b exp=0/0/1", out_valid, out_addr, inst_ren);
        end
        drive(1'b0, 1'b0, 1'b0, '0);
        n_checks++; if (count !== CW'(1)) begin n_fail++; $display("FAIL nobypass_count got=%0d exp=1", count); end
`endif
        drive(1'b0, 1'b1, 1'b0, '0);
    endtask

    task automatic test_wrap();
        drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        drive(1'b1, 1'b0, 1'b0, '0);
        n_checks++; if (inst_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pc got=%h exp=fffffffc", inst_addr); end
        drive(1'b1, 1'b0, 1'b0, '0);
        n_checks++; if (inst_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_pc0 got=%h exp=0", inst_addr); end
        drive(1'b0, 1'b1, 1'b0, '0);
        n_checks++; if (out_addr !== 32'hFFFF_FFFC || out_addr_next !== 32'h0) begin
            n_fail++; $display("FAIL wrap_head got=%h/%h exp=fffffffc/0", out_addr, out_addr_next);
        end
        drive(1'b0, 1'b1, 1'b0, '0);
        n_checks++; if (out_valid !== 1'b1 || out_addr !== 32'h0 || out_data !== mem_word(32'h0)) begin
            n_fail++; $display("FAIL wrap_next got=%b/%h exp=1/0", out_valid, out_addr);
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] ra;
        for (int i = 0; i < 300; i++) begin
            ra = $urandom();
            ra[1:0] = 2'b00;
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0, ra);
            n_checks++; if (inst_ren !== exp_ren || inst_addr !== m_pc) begin
                n_fail++; $display("FAIL rand_fetch got=%b/%h exp=%b/%h", inst_ren, inst_addr, exp_ren, m_pc);
            end
            n_checks++; if (out_valid !== exp_valid || count !== CW'(exp_q.size())) begin
                n_fail++; $display("FAIL rand_state got=%b/%0d exp=%b/%0d", out_valid, count, exp_valid, exp_q.size());
            end
            if (exp_valid) begin
                n_checks++; if (out_addr !== exp_head || out_data !== mem_word(exp_head) || out_addr_next !== exp_head + 32'd4) begin
                    n_fail++; $display("FAIL rand_head got=%h/%h/%h exp=%h/%h/%h", out_addr, out_data, out_addr_next,
                                       exp_head, mem_word(exp_head), exp_head + 32'd4);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 1'b0, 1'b0, '0);
        drive(1'b1, 1'b0, 1'b0, '0);
        #1 rst = 1'b1;
        #1;
        n_checks++; if (count !== '0 || out_valid !== 1'b0 || inst_ren !== 1'b0 || inst_addr !== 32'h0) begin
            n_fail++; $display("FAIL areset_state got=%0d/%b/%b/%h exp=0/0/0/0", count, out_valid, inst_ren, inst_addr);
        end
        n_checks++; if ({out_addr, out_data, out_addr_next} !== '0) begin
            n_fail++; $display("FAIL areset_outs got=%h/%h/%h exp=0", out_addr, out_data, out_addr_next);
        end
        pend = 1'b0;
        exp_q.delete();
        m_pc = '0;
        @(negedge clk);
        fetch_en = 1'b0; out_ready = 1'b0; redirect_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b0, '0);
        n_checks++; if (inst_ren !== 1'b1 || inst_addr !== 32'h0) begin
            n_fail++; $display("FAIL areset_first got=%b/%h exp=1/0", inst_ren, inst_addr);
        end
        drive(1'b0, 1'b0, 1'b0, '0);
        n_checks++; if (count !== CW'(1) || out_addr !== 32'h0 || out_data !== mem_word(32'h0)) begin
            n_fail++; $display("FAIL areset_refill got=%0d/%h exp=1/0", count, out_addr);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain_full();
        test_redirect();
        test_redirect_pop();
        test_stall();
        test_bypass();
        test_wrap();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Parametrised instruction-fetch front end for the pipelined MIPS CPU, generalising the single-register IF stage into a PC generator plus a DEPTH-entry prefetch queue. It issues sequential fetches to instruction memory, buffers {address, instruction, next address} entries, and hands them to ID through a valid/ready handshake. A redirect from a resolved branch or jump flushes all buffered entries and restarts fetch at the target.

## Interface
- ADDR_WIDTH, 32, PC / instruction address width
- DATA_WIDTH, 32, instruction word width
- DEPTH, 4, queue entries; power of two, ≥2
- RESET_PC, 0, PC value after reset
- PC_STEP, 4, sequential PC increment

- clk  in  1  main clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- fetch_en  in  1  allow new fetches; 0 stalls fetch (queue still drains)
- redirect_en  in  1  flush queue and load redirect_addr into PC
- redirect_addr  in  ADDR_WIDTH  redirect target
- inst_ren  out  1  instruction read enable
- inst_addr  out  ADDR_WIDTH  fetch address (current PC)
- inst_data  in  DATA_WIDTH  instruction word; combinational read, valid same cycle as inst_addr
- out_valid  out  1  head entry valid
- out_ready  in  1  ID accepts head entry
- out_addr  out  ADDR_WIDTH  head instruction address
- out_addr_next  out  ADDR_WIDTH  head address + PC_STEP
- out_data  out  DATA_WIDTH  head instruction word
- count  out  $clog2(DEPTH+1)  number of buffered entries

## Operation
- State: PC register, DEPTH-entry storage of {addr, data}, read/write pointers ($clog2(DEPTH) bits, wrap modulo DEPTH), count.
- pop = out_valid & out_ready. push = inst_ren.
- inst_ren = ~rst & fetch_en & ~redirect_en & (count < DEPTH | pop). Full queue with simultaneous pop still fetches.
- inst_addr = PC. On push: entry {PC, inst_data} written at write pointer; PC ← PC + PC_STEP (modulo 2^ADDR_WIDTH, wraps silently).
- Simultaneous push and pop: count unchanged, both pointers advance.
- out_valid = (count ≠ 0). out_addr/out_data = head entry; driven 0 when count = 0. out_addr_next = out_addr + PC_STEP (computed from head, 0 + PC_STEP when empty is not required; drive 0 when empty).
- Redirect (priority over everything except rst): PC ← redirect_addr; pointers and count ← 0; no fetch that cycle. A pop in the same cycle is a completed handshake (ID owns that entry); all other entries are discarded.
- fetch_en = 0: PC holds, no push; pops continue.

## Timing
- Reset values: PC = RESET_PC, count = 0, pointers = 0, out_valid = 0, out_addr/out_data/out_addr_next = 0, inst_ren = 0.
- Reset asserted mid-operation clears all state immediately (asynchronous); buffered entries lost.
- First fetch: first rising edge after rst deasserts with fetch_en = 1; inst_addr = RESET_PC in that cycle.
- Fetch-to-output latency: 1 cycle (entry fetched in cycle N visible on out_* in cycle N+1).
- Redirect in cycle N: cycle N+1 has count = 0, inst_addr = redirect_addr, inst_ren = fetch_en; target appears on out_* in cycle N+2.
- Throughput: one entry per cycle in and out in steady state.

## Configuration
- FETCH_BYPASS_EN defined: when count = 0 and inst_ren = 1, out_valid = 1 and out_addr/out_data = {inst_addr, inst_data} combinationally; if out_ready = 1 that cycle the word is consumed and not written to the queue (count stays 0). Fetch-to-output latency 0; redirect target visible in cycle N+1.
- Not defined: no combinational path from inst_data to out_*; latency fixed at 1 cycle as above.

## Test plan
- Reset release, fetch_en = 1, out_ready = 0, DEPTH = 4: inst_addr 0x0, 0x4, 0x8, 0xC on four consecutive cycles; count 1→4; then inst_ren = 0, inst_addr holds 0x10.
- From full, out_ready = 1 continuously: out_addr 0x0, 0x4, 0x8, 0xC, 0x10… one per cycle; count stays 4; out_addr_next = out_addr + 4.
- count = 3, redirect_en = 1 with redirect_addr = 0x100: redirect cycle inst_ren = 0; next cycle count = 0, out_valid = 0, inst_addr = 0x100; cycle after, out_addr = 0x100.
- Redirect coincident with pop of head 0x20: consumer receives 0x20 exactly once; none of the younger entries ever appear on out_*.
- fetch_en = 0 for 3 cycles with out_ready = 1: queue drains to count = 0, PC unchanged; rst pulse mid-stream returns all outputs to reset values without waiting for clk.
- PC near wrap (redirect to 0xFFFF_FFFC): entries 0xFFFF_FFFC then 0x0; with FETCH_BYPASS_EN, empty queue + out_ready = 1 shows out_addr = inst_addr in the fetch cycle and count remains 0.
